// File: rtl/reg_share_arbiter_pkg.sv
// reg_share_pkg: shared types and helpers for the register-sharing arbiter
package reg_share_pkg;
   typedef enum logic {IDLE, LOCKED} state_t;
   localparam int NREQ_DEF = 4;
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int OWNER_W_DEF = idx_w(NREQ_DEF);
   function automatic logic [31:0] onehot(input int unsigned idx);
      return 32'd1 << idx;
   endfunction
endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting just after ptr
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   win,
   output logic            any
);
   logic [IW-1:0] i;
   // Walk from the farthest candidate down so the nearest one after ptr wins.
   always_comb begin
      win = '0;
      any = 1'b0;
      i = '0;
      for (int k = NREQ; k >= 1; k--) begin
         i = IW'((int'(ptr) + k) % NREQ);
         if (req[i]) begin
            win = i;
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin write arbiter for one shared register
// with bounded owner lock bursts.
module reg_share_arbiter import reg_share_pkg::*; #(
   parameter int WIDTH = 4,
   parameter int NREQ = 4,
   parameter int LOCK_MAX = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NREQ-1:0]             req,
   input  logic [NREQ-1:0]             lock,
   input  logic [NREQ-1:0][WIDTH-1:0]  wdata,
   output logic [NREQ-1:0]             gnt,
   output logic [WIDTH-1:0]            q,
   output logic                        q_valid,
   output logic [idx_w(NREQ)-1:0]      owner,
   output logic                        locked,
   output logic                        lock_timeout
);
   localparam int OW = idx_w(NREQ);
   localparam int CW = $clog2(LOCK_MAX + 1);
   state_t state, state_nx;
   logic [OW-1:0] ptr, win, wsel;
   logic [CW-1:0] cnt, cnt_nx;
   logic any, wr, timeout_nx;
   rr_pick #(.NREQ(NREQ), .IW(OW)) u_pick (
      .req(req),
      .ptr(ptr),
      .win(win),
      .any(any)
   );
   // While locked only the owner may write; exit on lock drop or counter limit.
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      wsel = win;
      wr = 1'b0;
      timeout_nx = 1'b0;
      if (state == IDLE) begin
         wr = any;
         if (any && lock[win]) begin
            state_nx = LOCKED;
            cnt_nx = CW'(1);
         end
      end else begin
         wsel = owner;
         wr = req[owner];
         cnt_nx = cnt + CW'(1);
         if (!lock[owner] || cnt == CW'(LOCK_MAX)) begin
            state_nx = IDLE;
            cnt_nx = '0;
            timeout_nx = lock[owner];
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr <= OW'(NREQ - 1);
         cnt <= '0;
         q <= '0;
         q_valid <= 1'b0;
         gnt <= '0;
         owner <= '0;
         lock_timeout <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         lock_timeout <= timeout_nx;
         gnt <= wr ? NREQ'(onehot(int'(wsel))) : '0;
         if (wr) begin
            q <= wdata[wsel];
            owner <= wsel;
            ptr <= wsel;
            q_valid <= 1'b1;
         end
      end
   end
   assign locked = (state == LOCKED);
endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit holding register among NREQ requesters. Each cycle it grants at most one write, captures the winner's data into the register, and optionally lets the winner lock the register for a bounded burst of consecutive writes. It sits in front of the shared storage/flip-flop datapath and is its only write path.

## Interface

**Parameters**
- `WIDTH`, 4: data width of the shared register.
- `NREQ`, 4: number of requesters. Must be ≥ 2.
- `LOCK_MAX`, 8: maximum number of cycles a lock may be held before forced release. Must be ≥ 1.

**Ports**
- `clk` input 1: single clock; all state updates on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input NREQ: write request per requester; held until that requester's `gnt` bit is seen.
- `lock` input NREQ: requester asks to keep ownership after its grant; sampled with `req`.
- `wdata` input NREQ×WIDTH: write data per requester.
- `gnt` output NREQ: registered, one-hot or zero; one-cycle pulse per accepted write.
- `q` output WIDTH: shared register contents.
- `q_valid` output 1: register has been written since reset.
- `owner` output $clog2(NREQ): index of the last writer.
- `locked` output 1: high while in LOCKED state.
- `lock_timeout` output 1: one-cycle pulse on forced release.

## Operation

**Reset values:** `q`=0, `q_valid`=0, `gnt`=0, `owner`=0, `locked`=0, `lock_timeout`=0, state=IDLE, rr pointer=NREQ-1 (so requester 0 has first priority), lock counter=0.

**Arbitration:** winner = first requester with `req` high, searching ptr+1, ptr+2, … modulo NREQ, where ptr is the last winner.

**State machine:**
- **IDLE**
  - If no `req` is high, nothing changes.
  - If any `req` is high:
    - `q` ← `wdata[win]`, `owner` ← win, `gnt` ← onehot(win), ptr ← win, `q_valid` ← 1.
    - If `lock[win]` is high: go to LOCKED and set the counter to 1.
- **LOCKED**
  - Only the owner's `req` is honoured. Other requests are ignored and receive no `gnt`.
  - If `req[owner]` is high: write as above (`gnt[owner]` pulses).
  - Every cycle in LOCKED increments the counter.
  - Exit to IDLE when either:
    - `lock[owner]` is low. A same-cycle `req[owner]` is still written.
    - The counter equals LOCK_MAX. This is a forced release: `lock_timeout` pulses and the write in that cycle is still honoured.
  - After any exit, arbitration resumes at ptr+1, so the former owner has lowest priority.

**Boundary cases:**
- **Simultaneous requests:** exactly one grant per cycle.
- **Pointer wrap:** ptr = NREQ-1 wraps to a search starting at 0.
- **Lock without req:** a `lock` with `req` low is ignored.
- **Owner drops req while holding lock:** stays LOCKED with no writes until release or timeout.
- **Reset mid-lock:** `rst_n` low asynchronously returns all state to reset values immediately.

## Timing

- Request-to-grant latency: 1 cycle. `req` sampled at edge N gives `gnt` high and `q` updated after edge N.
- `gnt` is high for exactly one cycle per write. A requester that keeps `req` high after its `gnt` is treated as a new request.
- `q`, `owner` and `gnt` change on the same edge.
- `locked` is high starting the cycle after the locking grant, and goes low the cycle after the exit edge.
- `lock_timeout` is high in the same cycle that `locked` falls.
- Worst-case wait for a requester: (NREQ-1)×LOCK_MAX + NREQ cycles.

## Structure

**Package `reg_share_pkg`:**
- `state_t` enum {IDLE, LOCKED}.
- Helper function `onehot(idx)`.
- Owner-index width localparam derived from NREQ.

**Sub-module `rr_pick`:** purely combinational.
- Inputs: `req` vector, `ptr`.
- Outputs: `win` index, `any` flag.
- Instantiated once.

The top level holds the FSM, lock counter and register.

## Test plan

- **Post-reset round-robin:** after reset release, `req`=4'b1111 held for 4 cycles (lock=0) → `gnt` sequence 0001, 0010, 0100, 1000; `q` follows `wdata[0..3]`.
- **Single requester with pointer wrap:** ptr=3, `req`=4'b0001 → `gnt`=0001 after 1 cycle; `owner`=0; `q_valid` rises.
- **Lock burst:** `req[2]`=`lock[2]`=1 for 3 cycles while `req[0]`=1, then `lock[2]`=0 → three `gnt[2]` pulses, `locked`=1, no `gnt[0]`; after release, next grant goes to requester 0.
- **Timeout:** LOCK_MAX=8, requester 1 holds `req`+`lock` forever, `req[3]`=1 → `lock_timeout` pulses after 8 locked cycles, `locked` falls, next `gnt`=1000.
- **Reset mid-lock:** assert `rst_n`=0 mid-burst → `q`=0, `gnt`=0, `locked`=0 with no clock edge; after release, requester 0 has priority.
- **Simultaneous release and req:** `lock[owner]` falls in the same cycle as `req[owner]`=1 → that write is accepted (`gnt` pulse), then state returns to IDLE.
